// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser_if
// Brief    : Payload output stream of the UART frame parser (valid/ready with
//            an end-of-frame marker).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_frame_parser_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  // Producer side: the frame parser.
  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  // Consumer side.
  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Brief    : Delimits SOF/LEN/payload/CHK frames from a UART receiver, checks
//            the XOR checksum and streams the buffered payload out only once
//            the whole frame is known good.
//            Optional feature: define UART_FRAME_TIMEOUT_EN to build the
//            inter-byte timeout (error code 3).
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 25_000
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [7:0]        rx_data,
  input  wire logic              rx_done,
  uart_frame_parser_if.master    out_if,
  output logic                   frame_ok,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  output logic                   busy
);

  // Buffer is addressed with the low bits of the 8-bit index; depth is
  // rounded up to a power of two so every address is in range.
  localparam int         c_IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         c_DEPTH     = 1 << c_IDX_W;
  localparam logic [7:0] c_MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] c_ERR_OVERRUN = 2'd0;
  localparam logic [1:0] c_ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] c_ERR_BAD_CHK = 2'd2;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_chk;
  logic [7:0] r_out_data;
  logic       r_out_valid;
  logic       r_out_last;
  logic [7:0] r_buf [c_DEPTH];

  logic       w_buf_we;
  logic [7:0] w_idx_nxt;
  logic       w_xfer;
  logic       w_tmo_fire;

  assign w_buf_we  = (r_state == S_PAYLOAD) && rx_done;
  assign w_idx_nxt = r_idx + 8'd1;
  assign w_xfer    = r_out_valid && out_if.out_ready;

  assign out_if.out_data  = r_out_data;
  assign out_if.out_valid = r_out_valid;
  assign out_if.out_last  = r_out_last;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               w_in_frame;

  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_tmo_fire = w_in_frame && !rx_done &&
                      (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte silence counter; idle (held at zero) outside the receive states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (w_in_frame && !rx_done && !w_tmo_fire) begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  assign w_tmo_fire = 1'b0;
`endif

  // Payload storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_idx[c_IDX_W-1:0]] <= rx_data;
    end
  end

  // Frame FSM with registered status and stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_len       <= 8'd0;
      r_idx       <= 8'd0;
      r_chk       <= 8'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      busy        <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_done && (rx_data == SOF_BYTE)) begin
            r_state <= S_LEN;
            busy    <= 1'b1;
          end
        end
        S_LEN: begin
          if (rx_done) begin
            r_len <= rx_data;
            r_chk <= rx_data;
            if ((rx_data == 8'd0) || (rx_data > c_MAX_LEN_B)) begin
              frame_err <= 1'b1;
              err_code  <= c_ERR_BAD_LEN;
              r_state   <= S_IDLE;
              busy      <= 1'b0;
            end else begin
              r_idx   <= 8'd0;
              r_state <= S_PAYLOAD;
            end
          end else if (w_tmo_fire) begin
            frame_err <= 1'b1;
            err_code  <= c_ERR_TIMEOUT;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        S_PAYLOAD: begin
          if (rx_done) begin
            r_chk <= r_chk ^ rx_data;
            r_idx <= w_idx_nxt;
            if (r_idx == (r_len - 8'd1)) begin
              r_state <= S_CHK;
            end
          end else if (w_tmo_fire) begin
            frame_err <= 1'b1;
            err_code  <= c_ERR_TIMEOUT;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        S_CHK: begin
          if (rx_done) begin
            if (rx_data == r_chk) begin
              // Present the first payload byte in the same cycle as frame_ok.
              frame_ok    <= 1'b1;
              r_idx       <= 8'd0;
              r_state     <= S_SEND;
              r_out_valid <= 1'b1;
              r_out_data  <= r_buf[{c_IDX_W{1'b0}}];
              r_out_last  <= (r_len == 8'd1);
            end else begin
              frame_err <= 1'b1;
              err_code  <= c_ERR_BAD_CHK;
              r_state   <= S_IDLE;
              busy      <= 1'b0;
            end
          end else if (w_tmo_fire) begin
            frame_err <= 1'b1;
            err_code  <= c_ERR_TIMEOUT;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        S_SEND: begin
          // Bytes arriving while draining are dropped unparsed.
          if (rx_done) begin
            frame_err <= 1'b1;
            err_code  <= c_ERR_OVERRUN;
          end
          if (w_xfer) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= S_IDLE;
              busy        <= 1'b0;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_data <= r_buf[w_idx_nxt[c_IDX_W-1:0]];
              r_out_last <= (w_idx_nxt == (r_len - 8'd1));
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
